// File: rtl/out_serial_tx.sv
// Serial transmitter for the 4-bit output register: snoop, FIFO, async frame.
// Optional even-parity bit when OUT_SERIAL_TX_PARITY_EN is defined.
module out_serial_tx #(
  parameter int unsigned BAUD_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic MainClock,
  input  logic MainReset,
  input  logic LoadOut,
  input  logic Out0,
  input  logic Out1,
  input  logic Out2,
  input  logic Out3,
  output logic TxOut,
  output logic TxBusy,
  output logic FifoFull,
  output logic Overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] BAUD_MAX = 8'(BAUD_DIV - 1);
  localparam logic [AW:0] PTR_ONE = 1;

`ifdef OUT_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  state_e state_q, state_d;

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [3:0]  mem_q [FIFO_DEPTH];
  logic        pend_q;
  logic        ovf_q, ovf_d;
  logic [3:0]  sh_q, sh_d;
  logic [7:0]  baud_q, baud_d;
  logic [1:0]  bit_q, bit_d;

  logic       empty;
  logic       full;
  logic       tick;
  logic       push;
  logic       pop;
  logic       wr_en;
  logic [3:0] word;

  assign word  = {Out3, Out2, Out1, Out0};
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign tick  = (baud_q == BAUD_MAX);
  assign push  = pend_q;
  // A pop frees the head slot on the same edge, so a push at full still fits.
  assign wr_en = push && (!full || pop);

  always_comb begin
    state_d = state_q;
    baud_d  = tick ? 8'd0 : baud_q + 8'd1;
    bit_d   = bit_q;
    pop     = 1'b0;
    TxOut   = 1'b1;
    TxBusy  = 1'b1;
    unique case (state_q)
      IDLE: begin
        TxBusy = 1'b0;
        baud_d = 8'd0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        TxOut = 1'b0;
        if (tick) begin
          state_d = DATA;
          bit_d   = 2'd0;
        end
      end
      DATA: begin
        TxOut = sh_q[bit_q];
        if (tick) begin
          if (bit_q == 2'd3) begin
`ifdef OUT_SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 2'd1;
          end
        end
      end
`ifdef OUT_SERIAL_TX_PARITY_EN
      PARITY: begin
        TxOut = ^sh_q;
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = 8'd0;
      end
    endcase

    sh_d  = pop ? mem_q[rd_q[AW-1:0]] : sh_q;
    wr_d  = wr_en ? wr_q + PTR_ONE : wr_q;
    rd_d  = pop ? rd_q + PTR_ONE : rd_q;
    ovf_d = ovf_q | (push && full && !pop);
  end

  assign FifoFull = full;
  assign Overflow = ovf_q;

  always_ff @(posedge MainClock or negedge MainReset) begin
    if (!MainReset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sh_q    <= 4'd0;
      baud_q  <= 8'd0;
      bit_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pend_q  <= LoadOut;
      ovf_q   <= ovf_d;
      sh_q    <= sh_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge MainClock) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= word;
    end
  end

endmodule

// File: tb/tb_out_serial_tx.sv
// Directed bench for out_serial_tx with a frame-decoding scoreboard.
// Build with OUT_SERIAL_TX_PARITY_EN defined to exercise the parity frame.
module tb_out_serial_tx;

  localparam int B = 4;
  localparam int D = 4;
`ifdef OUT_SERIAL_TX_PARITY_EN
  localparam int F = 7 * B;
`else
  localparam int F = 6 * B;
`endif

  logic       MainClock = 1'b0;
  logic       MainReset = 1'b0;
  logic       LoadOut   = 1'b0;
  logic [3:0] word_in   = 4'h0;
  logic       TxOut;
  logic       TxBusy;
  logic       FifoFull;
  logic       Overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [3:0] sb [$];
  logic [3:0] wq [$];
  int         starts [$];

  int         rs;
  int         ew;
  logic [3:0] rw;
  logic       rp;
  logic       rstop;
  logic       ralive;

  int         n;
  int         m;
  int         mism;
  int         drops;
  int         seg;
  logic       eb;
  logic [3:0] t2w;

  out_serial_tx #(
    .BAUD_DIV  (B),
    .FIFO_DEPTH(D)
  ) dut (
    .MainClock(MainClock),
    .MainReset(MainReset),
    .LoadOut  (LoadOut),
    .Out0     (word_in[0]),
    .Out1     (word_in[1]),
    .Out2     (word_in[2]),
    .Out3     (word_in[3]),
    .TxOut    (TxOut),
    .TxBusy   (TxBusy),
    .FifoFull (FifoFull),
    .Overflow (Overflow)
  );

  always #5 MainClock = ~MainClock;

  always @(posedge MainClock) cyc = cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // LoadOut high for wq.size() cycles; each word follows its strobe by one cycle.
  task automatic capture(output int nn);
    int k;
    k = wq.size();
    nn = 0;
    for (int i = 0; i <= k; i++) begin
      @(negedge MainClock);
      if (i == 0) nn = cyc + 1;
      LoadOut = (i < k);
      if (i > 0) word_in = wq[i-1];
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || TxBusy !== 1'b0) && t < 4000) begin
      @(negedge MainClock);
      t++;
    end
    chk({tag, "_queue"}, sb.size(), 0);
    chk({tag, "_idle"}, int'(TxBusy), 0);
  endtask

  // Frame receiver: samples each bit in its middle on falling edges.
  initial begin
    forever begin
      @(negedge MainClock);
      if (MainReset === 1'b1 && TxOut === 1'b0) begin
        rs = cyc;
        ralive = 1'b1;
        repeat (B / 2) @(negedge MainClock);
        for (int i = 0; i < 4; i++) begin
          repeat (B) @(negedge MainClock);
          ralive &= MainReset;
          rw[i] = TxOut;
        end
`ifdef OUT_SERIAL_TX_PARITY_EN
        repeat (B) @(negedge MainClock);
        ralive &= MainReset;
        rp = TxOut;
`endif
        repeat (B) @(negedge MainClock);
        ralive &= MainReset;
        rstop = TxOut;
        if (ralive) begin
          starts.push_back(rs);
          ew = (sb.size() != 0) ? int'(sb.pop_front()) : -1;
          chk("rx_word", int'(rw), ew);
          chk("rx_stop", int'(rstop), 1);
`ifdef OUT_SERIAL_TX_PARITY_EN
          chk("rx_parity", int'(rp), (ew < 0) ? -1 : int'(^ew[3:0]));
`endif
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_txout", int'(TxOut), 1);
    chk("rst_busy", int'(TxBusy), 0);
    chk("rst_full", int'(FifoFull), 0);
    chk("rst_ovf", int'(Overflow), 0);
    repeat (2) @(negedge MainClock);
    MainReset = 1'b1;
    repeat (3) @(negedge MainClock);

    // single word, cycle-exact waveform
    t2w = 4'b1011;
    wq.delete();
    wq.push_back(t2w);
    sb.push_back(t2w);
    starts.delete();
    capture(n);
    @(negedge MainClock);
    word_in = 4'h0;
    while (cyc < n + 2) @(negedge MainClock);
    mism = 0;
    for (int o = 0; o < F; o++) begin
      seg = o / B;
      if (seg == 0) eb = 1'b0;
      else if (seg <= 4) eb = t2w[seg-1];
`ifdef OUT_SERIAL_TX_PARITY_EN
      else if (seg == 5) eb = ^t2w;
`endif
      else eb = 1'b1;
      if (TxOut !== eb || TxBusy !== 1'b1) mism++;
      @(negedge MainClock);
    end
    chk("t2_waveform", mism, 0);
    chk("t2_busy_end", int'(TxBusy), 0);
    chk("t2_line_idle", int'(TxOut), 1);
    drain("t2");
    chk("t2_latency", (starts.size() == 1) ? starts[0] : -1, n + 2);

    // back-to-back frames
    starts.delete();
    wq.delete();
    wq.push_back(4'h3);
    wq.push_back(4'hC);
    wq.push_back(4'h5);
    sb.push_back(4'h3);
    sb.push_back(4'hC);
    sb.push_back(4'h5);
    capture(n);
    while (cyc < n + 2) @(negedge MainClock);
    drops = 0;
    for (int c = 0; c < 3 * F; c++) begin
      if (TxBusy !== 1'b1) drops++;
      @(negedge MainClock);
    end
    chk("t3_busy_gap", drops, 0);
    drain("t3");
    chk("t3_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("t3_gap01", starts[1] - starts[0], F);
      chk("t3_gap12", starts[2] - starts[1], F);
    end

    // overflow: six captures, five survive
    wq.delete();
    for (int i = 1; i <= 6; i++) wq.push_back(4'(i));
    for (int i = 1; i <= 5; i++) sb.push_back(4'(i));
    capture(n);
    chk("t4_full", int'(FifoFull), 1);
    chk("t4_ovf_before", int'(Overflow), 0);
    @(negedge MainClock);
    chk("t4_full_after", int'(FifoFull), 1);
    chk("t4_ovf_set", int'(Overflow), 1);
    drain("t4");
    chk("t4_ovf_sticky", int'(Overflow), 1);
    chk("t4_not_full", int'(FifoFull), 0);
    MainReset = 1'b0;
    #1;
    chk("t4_ovf_cleared", int'(Overflow), 0);
    @(negedge MainClock);
    MainReset = 1'b1;
    repeat (2) @(negedge MainClock);

    // push and pop on the same edge while full
    wq.delete();
    for (int i = 0; i < 5; i++) begin
      wq.push_back(4'(4'hA + i));
      sb.push_back(4'(4'hA + i));
    end
    capture(n);
    @(negedge MainClock);
    chk("t5_full", int'(FifoFull), 1);
    while (cyc < n + F - 1) @(negedge MainClock);
    wq.delete();
    wq.push_back(4'h9);
    sb.push_back(4'h9);
    capture(m);
    chk("t5_full_pre", int'(FifoFull), 1);
    @(negedge MainClock);
    chk("t5_full_post", int'(FifoFull), 1);
    chk("t5_no_ovf", int'(Overflow), 0);
    drain("t5");
    chk("t5_ovf_end", int'(Overflow), 0);

    // asynchronous reset during data bit 2
    wq.delete();
    for (int i = 0; i < 5; i++) begin
      wq.push_back(4'(4'h2 + i));
      sb.push_back(4'(4'h2 + i));
    end
    capture(n);
    while (cyc < n + 2 + 3 * B + 1) @(negedge MainClock);
    chk("t1_full_pre", int'(FifoFull), 1);
    chk("t1_busy_pre", int'(TxBusy), 1);
    #2;
    MainReset = 1'b0;
    #1;
    chk("t1_txout", int'(TxOut), 1);
    chk("t1_busy", int'(TxBusy), 0);
    chk("t1_full", int'(FifoFull), 0);
    chk("t1_ovf", int'(Overflow), 0);
    repeat (2 * B) @(negedge MainClock);
    sb.delete();
    MainReset = 1'b1;
    repeat (3 * F) @(negedge MainClock);
    chk("t1_stay_idle", int'(TxBusy), 0);
    chk("t1_line_high", int'(TxOut), 1);

`ifdef OUT_SERIAL_TX_PARITY_EN
    starts.delete();
    wq.delete();
    wq.push_back(4'b0111);
    wq.push_back(4'b0110);
    sb.push_back(4'b0111);
    sb.push_back(4'b0110);
    capture(n);
    drain("t6");
    chk("t6_frames", starts.size(), 2);
    if (starts.size() == 2) chk("t6_len", starts[1] - starts[0], 28);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
